// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_master
// Purpose  : CPU-side initiator for the memory-mapped I/O register bus.
//            Turns one CPU load/store (byte/half/word) into a single
//            ren/wen + ack handshake with byte-lane steering, byte enables
//            and load sign/zero extension.
// Ports    : clk, rst (async, active-high)
//            cpu_req/cpu_we/cpu_addr/cpu_size/cpu_signed/cpu_wdata  - CPU request
//            cpu_ready/cpu_done/cpu_err/cpu_rdata                   - CPU response
//            io_addr/io_wdata/io_ren/io_wen/io_ben                  - bus request
//            io_ack/io_rdata                                        - bus response
// Options  : IO_BUS_TIMEOUT_EN - when defined, REQ aborts with cpu_err after
//            TIMEOUT_CYCLES cycles without io_ack.
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_master
`ifdef IO_BUS_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 255)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic        io_ren,
  output logic        io_wen,
  output logic [3:0]  io_ben,
  input  logic        io_ack,
  input  logic [31:0] io_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        we_q;
  logic        rel_first;

  // Request decode from the live CPU inputs (used on the accept edge only).
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic [3:0]  ben_next;
  logic [31:0] wdata_next;

  assign is_half    = (cpu_size == 2'b01);
  assign is_word    = cpu_size[1];          // 11 behaves as word
  assign misaligned = (is_half & cpu_addr[0]) | (is_word & (cpu_addr[1:0] != 2'b00));

  always_comb begin
    ben_next   = 4'b0001 << cpu_addr[1:0];
    wdata_next = {4{cpu_wdata[7:0]}};
    if (is_word) begin
      ben_next   = 4'b1111;
      wdata_next = cpu_wdata;
    end else if (is_half) begin
      ben_next   = cpu_addr[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{cpu_wdata[15:0]}};
    end
  end

  // Load lane extraction from the latched address/size.
  logic [31:0] lane;
  logic [31:0] load_val;

  assign lane = io_rdata >> {io_addr[1:0], 3'b000};

  always_comb begin
    load_val = lane;
    if (size_q == 2'b00)
      load_val = {{24{signed_q & lane[7]}}, lane[7:0]};
    else if (size_q == 2'b01)
      load_val = {{16{signed_q & lane[15]}}, lane[15:0]};
  end

`ifdef IO_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] req_cnt;
  logic             timed_out;
  // True on the last permitted REQ cycle without an acknowledge.
  assign timed_out = (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
      rel_first <= 1'b0;
      cpu_ready <= 1'b1;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= 32'h0;
      io_addr   <= 32'h0;
      io_wdata  <= 32'h0;
      io_ren    <= 1'b0;
      io_wen    <= 1'b0;
      io_ben    <= 4'b0000;
`ifdef IO_BUS_TIMEOUT_EN
      req_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            size_q    <= cpu_size;
            signed_q  <= cpu_signed;
            we_q      <= cpu_we;
            io_addr   <= cpu_addr;
            io_wdata  <= wdata_next;
            io_ben    <= ben_next;
            cpu_ready <= 1'b0;
            cpu_rdata <= 32'h0;
`ifdef IO_BUS_TIMEOUT_EN
            req_cnt   <= '0;
`endif
            if (misaligned) begin
              // Reject without touching the bus.
              cpu_err  <= 1'b1;
              cpu_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              cpu_err  <= 1'b0;
              io_ren   <= ~cpu_we;
              io_wen   <= cpu_we;
              state    <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (io_ack) begin
            io_ren    <= 1'b0;
            io_wen    <= 1'b0;
            rel_first <= 1'b1;
            state     <= S_REL;
          end
`ifdef IO_BUS_TIMEOUT_EN
          else if (timed_out) begin
            io_ren   <= 1'b0;
            io_wen   <= 1'b0;
            cpu_err  <= 1'b1;
            cpu_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            req_cnt <= req_cnt + 1'b1;
          end
`endif
        end

        S_REL: begin
          rel_first <= 1'b0;
          // Responder registers read data on its ack cycle, so it is
          // valid on the first cycle after the request drops.
          if (rel_first && !we_q)
            cpu_rdata <= load_val;
          if (!io_ack) begin
            cpu_done <= 1'b1;
            state    <= S_DONE;
          end
        end

        default: begin
          cpu_done  <= 1'b0;
          cpu_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bus_master
// Purpose  : Directed self-checking bench for io_bus_master with a simple
//            responder (ack 2 cycles after request, data registered on ack).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_signed = 1'b0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_ready;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_ren;
  logic        io_wen;
  logic [3:0]  io_ben;
  logic        io_ack;
  logic [31:0] io_rdata = 32'h0;

  always #5 clk = ~clk;

`ifdef IO_BUS_TIMEOUT_EN
  io_bus_master #(.TIMEOUT_CYCLES(16)) dut (
`else
  io_bus_master dut (
`endif
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_signed(cpu_signed), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_ren(io_ren), .io_wen(io_wen),
    .io_ben(io_ben), .io_ack(io_ack), .io_rdata(io_rdata)
  );

  // Responder
  logic [3:0]  rcnt = 4'd0;
  logic        ack_en = 1'b1;
  logic [31:0] resp_data = 32'h0;

  assign io_ack = (io_ren | io_wen) && ack_en && (rcnt >= 4'd2);

  always @(posedge clk) begin
    rcnt     <= (io_ren | io_wen) ? ((rcnt == 4'd15) ? rcnt : rcnt + 4'd1) : 4'd0;
    io_rdata <= io_ack ? resp_data : 32'hDEAD_BEEF;
  end

  // Checking
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-access observations
  int          cyc;
  int          done_cyc;
  int          ren_cycles;
  int          wen_cycles;
  logic        bus_seen;
  logic [3:0]  ben_seen;
  logic [31:0] wd_seen;
  logic [31:0] addr_seen;
  logic        err_seen;
  logic [31:0] rdata_seen;

  task automatic start_access(input logic we, input logic [31:0] a, input logic [1:0] sz,
                              input logic sg, input logic [31:0] wd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_size = sz; cpu_signed = sg; cpu_wdata = wd;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cyc = 1; done_cyc = -1; ren_cycles = 0; wen_cycles = 0; bus_seen = 1'b0;
    ben_seen = 4'h0; wd_seen = 32'h0; addr_seen = 32'h0; err_seen = 1'b0; rdata_seen = 32'h0;
  endtask

  task automatic sample_bus();
    if (io_ren) ren_cycles++;
    if (io_wen) wen_cycles++;
    if ((io_ren | io_wen) && !bus_seen) begin
      bus_seen = 1'b1; ben_seen = io_ben; wd_seen = io_wdata; addr_seen = io_addr;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      sample_bus();
      if (cpu_done) begin
        done_cyc = cyc; err_seen = cpu_err; rdata_seen = cpu_rdata;
        break;
      end
      advance();
    end
    check_eq("done_seen", 32'(done_cyc >= 0), 32'd1);
    advance();
    check_eq("ready_after_done", 32'(cpu_ready), 32'd1);
    check_eq("done_one_cycle", 32'(cpu_done), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(cpu_ready), 32'd1);
    check_eq("rst_ren_wen", {30'd0, io_ren, io_wen}, 32'd0);
    check_eq("rst_done_err", {30'd0, cpu_done, cpu_err}, 32'd0);
    check_eq("rst_rdata", cpu_rdata, 32'd0);
    check_eq("rst_ben", 32'(io_ben), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: LW aligned
    resp_data = 32'h0000_0401;
    start_access(1'b0, 32'h1F80_1070, 2'b10, 1'b0, 32'h0);
    wait_done(50);
    check_eq("lw_done_cyc", 32'(done_cyc), 32'd5);
    check_eq("lw_ben", 32'(ben_seen), 32'hF);
    check_eq("lw_addr", addr_seen, 32'h1F80_1070);
    check_eq("lw_ren_cycles", 32'(ren_cycles), 32'd3);
    check_eq("lw_wen_cycles", 32'(wen_cycles), 32'd0);
    check_eq("lw_rdata", rdata_seen, 32'h0000_0401);
    check_eq("lw_err", 32'(err_seen), 32'd0);
    check_eq("lw_rdata_hold", cpu_rdata, 32'h0000_0401);

    // 2: LB signed / unsigned on lane 2
    resp_data = 32'h0080_0000;
    start_access(1'b0, 32'h1F80_1072, 2'b00, 1'b1, 32'h0);
    wait_done(50);
    check_eq("lbs_ben", 32'(ben_seen), 32'h4);
    check_eq("lbs_rdata", rdata_seen, 32'hFFFF_FF80);
    start_access(1'b0, 32'h1F80_1072, 2'b00, 1'b0, 32'h0);
    wait_done(50);
    check_eq("lbu_rdata", rdata_seen, 32'h0000_0080);

    // LH signed upper half
    resp_data = 32'h8001_0000;
    start_access(1'b0, 32'h1F80_1072, 2'b01, 1'b1, 32'h0);
    wait_done(50);
    check_eq("lhs_ben", 32'(ben_seen), 32'hC);
    check_eq("lhs_rdata", rdata_seen, 32'hFFFF_8001);

    // 3: SH upper half
    start_access(1'b1, 32'h1F80_104A, 2'b01, 1'b0, 32'h0000_1234);
    wait_done(50);
    check_eq("sh_wen_cycles", 32'(wen_cycles), 32'd3);
    check_eq("sh_ren_cycles", 32'(ren_cycles), 32'd0);
    check_eq("sh_ben", 32'(ben_seen), 32'hC);
    check_eq("sh_wdata", wd_seen, 32'h1234_1234);
    check_eq("sh_done_cyc", 32'(done_cyc), 32'd5);
    check_eq("sh_rdata", rdata_seen, 32'h0);

    // SB lane 1
    start_access(1'b1, 32'h1F80_1071, 2'b00, 1'b0, 32'h0000_00AB);
    wait_done(50);
    check_eq("sb_ben", 32'(ben_seen), 32'h2);
    check_eq("sb_wdata", wd_seen, 32'hABAB_ABAB);

    // 4: misaligned LW
    start_access(1'b0, 32'h1F80_1072, 2'b10, 1'b0, 32'h0);
    wait_done(50);
    check_eq("mis_done_cyc", 32'(done_cyc), 32'd1);
    check_eq("mis_err", 32'(err_seen), 32'd1);
    check_eq("mis_rdata", rdata_seen, 32'h0);
    check_eq("mis_bus", 32'(ren_cycles + wen_cycles), 32'd0);

    // 5: responder never acks
    ack_en = 1'b0;
    start_access(1'b0, 32'h1F80_1070, 2'b10, 1'b0, 32'h0);
`ifdef IO_BUS_TIMEOUT_EN
    wait_done(100);
    check_eq("to_ren_cycles", 32'(ren_cycles), 32'd16);
    check_eq("to_done_cyc", 32'(done_cyc), 32'd17);
    check_eq("to_err", 32'(err_seen), 32'd1);
    check_eq("to_rdata", rdata_seen, 32'h0);
    ack_en = 1'b1;
`else
    for (int i = 0; i < 300; i++) begin
      sample_bus();
      advance();
    end
    check_eq("wait_ren_held", 32'(io_ren), 32'd1);
    check_eq("wait_no_done", 32'(cpu_done), 32'd0);
    resp_data = 32'h1357_9BDF;
    ack_en = 1'b1;
    wait_done(50);
    check_eq("wait_err", 32'(err_seen), 32'd0);
    check_eq("wait_rdata", rdata_seen, 32'h1357_9BDF);
`endif

    // 6: async reset during REQ
    resp_data = 32'hCAFE_F00D;
    start_access(1'b0, 32'h1F80_1074, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("arst_ren", 32'(io_ren), 32'd0);
    check_eq("arst_ready", 32'(cpu_ready), 32'd1);
    check_eq("arst_done", 32'(cpu_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (cpu_done) done_cyc = i;
    end
    check_eq("arst_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    start_access(1'b0, 32'h1F80_1074, 2'b10, 1'b0, 32'h0);
    wait_done(50);
    check_eq("post_rst_done_cyc", 32'(done_cyc), 32'd5);
    check_eq("post_rst_rdata", rdata_seen, 32'hCAFE_F00D);
    check_eq("post_rst_err", 32'(err_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
